// File: rtl/alu_exec_unit_if.sv
//------------------------------------------------------------------------------
// alu_exec_unit_if : operand/result bundle between the EX pipe and the ALU.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface alu_exec_unit_if #(
  parameter int W   = 32,
  parameter int SHW = 5
);
  logic           flush;
  logic           in_valid;
  logic           in_ready;
  logic [3:0]     alu_ctrl;
  logic [W-1:0]   src_a;
  logic [W-1:0]   src_b;
  logic [SHW-1:0] shamt;
  logic           out_valid;
  logic [W-1:0]   result;
  logic           zero;
  logic           overflow;
  logic           busy;

  modport master (
    output flush, in_valid, alu_ctrl, src_a, src_b, shamt,
    input  in_ready, out_valid, result, zero, overflow, busy
  );

  modport slave (
    input  flush, in_valid, alu_ctrl, src_a, src_b, shamt,
    output in_ready, out_valid, result, zero, overflow, busy
  );
endinterface

`default_nettype wire

// File: rtl/alu_exec_unit.sv
//------------------------------------------------------------------------------
// alu_exec_unit : EX-stage execute unit, single-cycle arith/logic and
//                 iterative 1-bit-per-cycle shifts that stall via in_ready.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_exec_unit #(
  parameter int W   = 32,
  parameter int SHW = 5
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  alu_exec_unit_if.slave   bus
);

  localparam logic [3:0] c_OP_SLL = 4'b0000;
  localparam logic [3:0] c_OP_ADD = 4'b0001;
  localparam logic [3:0] c_OP_SUB = 4'b0010;
  localparam logic [3:0] c_OP_AND = 4'b0100;
  localparam logic [3:0] c_OP_OR  = 4'b0101;
  localparam logic [3:0] c_OP_XOR = 4'b0110;
  localparam logic [3:0] c_OP_NOR = 4'b0111;
  localparam logic [3:0] c_OP_SLT = 4'b1010;
  localparam logic [3:0] c_OP_SRL = 4'b1111;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [W-1:0]   r_acc;
  logic [SHW-1:0] r_cnt;
  logic           r_dir_right;
  logic           r_out_valid;
  logic [W-1:0]   r_result;
  logic           r_zero;
  logic           r_overflow;

  logic [W-1:0]   w_sum;
  logic [W-1:0]   w_diff;
  logic           w_add_ovf;
  logic           w_sub_ovf;
  logic [W-1:0]   w_alu_res;
  logic           w_alu_ovf;
  logic           w_is_shift;
  logic           w_multi_cycle;
  logic           w_accept;
  logic           w_in_ready;
  logic           w_busy;
  logic [W-1:0]   w_acc_shifted;

  assign w_sum     = bus.src_a + bus.src_b;
  assign w_diff    = bus.src_a - bus.src_b;
  assign w_add_ovf = (bus.src_a[W-1] == bus.src_b[W-1]) && (w_sum[W-1]  != bus.src_a[W-1]);
  assign w_sub_ovf = (bus.src_a[W-1] != bus.src_b[W-1]) && (w_diff[W-1] != bus.src_a[W-1]);

  assign w_is_shift    = (bus.alu_ctrl == c_OP_SLL) || (bus.alu_ctrl == c_OP_SRL);
  assign w_multi_cycle = w_is_shift && (bus.shamt != '0);
  assign w_accept      = bus.in_valid && w_in_ready;
  assign w_acc_shifted = r_dir_right ? (r_acc >> 1) : (r_acc << 1);

  // A shift only reaches this path with shamt==0, so its result is src_b unchanged.
  always_comb begin
    w_alu_res = w_sum;
    w_alu_ovf = 1'b0;
    case (bus.alu_ctrl)
      c_OP_SLL, c_OP_SRL: w_alu_res = bus.src_b;
      c_OP_SUB: begin
        w_alu_res = w_diff;
        w_alu_ovf = w_sub_ovf;
      end
      c_OP_AND: w_alu_res = bus.src_a & bus.src_b;
      c_OP_OR:  w_alu_res = bus.src_a | bus.src_b;
      c_OP_XOR: w_alu_res = bus.src_a ^ bus.src_b;
      c_OP_NOR: w_alu_res = ~(bus.src_a | bus.src_b);
      c_OP_SLT: w_alu_res = {{(W-1){1'b0}}, ($signed(bus.src_a) < $signed(bus.src_b))};
      default: begin
        w_alu_res = w_sum;
        w_alu_ovf = w_add_ovf;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (w_accept && w_multi_cycle) begin
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_busy = 1'b1;
        if (r_cnt == SHW'(1)) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (bus.flush) begin
      w_state_nxt = S_IDLE;
    end
  end

  // Flush drops both the in-flight shift and any op offered in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_dir_right <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (bus.flush) begin
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_multi_cycle) begin
              r_acc       <= bus.src_b;
              r_cnt       <= bus.shamt;
              r_dir_right <= (bus.alu_ctrl == c_OP_SRL);
            end else begin
              r_result    <= w_alu_res;
              r_zero      <= (w_alu_res == '0);
              r_overflow  <= w_alu_ovf;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          r_acc <= w_acc_shifted;
          r_cnt <= r_cnt - SHW'(1);
          if (r_cnt == SHW'(1)) begin
            r_result    <= w_acc_shifted;
            r_zero      <= (w_acc_shifted == '0);
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.busy      = w_busy;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.zero      = r_zero;
  assign bus.overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
//------------------------------------------------------------------------------
// tb_alu_exec_unit : directed vector table, hand sequences and randomized ops
//                    against an arithmetic reference model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_exec_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [31:0] last_res = '0;

  always #5 clk = ~clk;

  alu_exec_unit_if #(.W(32), .SHW(5)) bus ();

  alu_exec_unit #(.W(32), .SHW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        ovf;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain signed/unsigned arithmetic; shifts as multiply/divide by 2^sh.
  function automatic void model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] sh, output logic [31:0] res, output logic ovf);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint s;
    logic [63:0] p;
    logic [63:0] pw;
    pw  = 64'd1 << sh;
    ovf = 1'b0;
    case (c)
      4'b0010: begin s = sa - sb; res = s[31:0]; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'b0100: res = a & b;
      4'b0101: res = a | b;
      4'b0110: res = a ^ b;
      4'b0111: res = ~(a | b);
      4'b1010: res = (sa < sb) ? 32'd1 : 32'd0;
      4'b0000: begin p = {32'd0, b} * pw; res = p[31:0]; end
      4'b1111: begin p = {32'd0, b} / pw; res = p[31:0]; end
      default: begin s = sa + sb; res = s[31:0]; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh,
                        input logic [31:0] er, input logic eo);
    int  lat, lows, busys, guard, exp_lat;
    bit  multi;
    multi   = ((c == 4'b0000) || (c == 4'b1111)) && (sh != 5'd0);
    // out_valid rises on the sh-th edge after the accept edge, seen at the following negedge.
    exp_lat = multi ? int'(sh) + 1 : 1;
    guard = 0;
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.alu_ctrl = c;
    bus.src_a    = a;
    bus.src_b    = b;
    bus.shamt    = sh;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1; lows = 0; busys = 0;
    while (!bus.out_valid && lat < 64) begin
      if (!bus.in_ready) lows++;
      if (bus.busy) busys++;
      @(negedge clk);
      lat++;
    end
    chk({tag, " out_valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " result"}, 64'(bus.result), 64'(er));
    chk({tag, " zero"}, 64'(bus.zero), 64'(er == 32'd0));
    chk({tag, " overflow"}, 64'(bus.overflow), 64'(eo));
    chk({tag, " stall"}, 64'(lows), multi ? 64'(sh) : 64'd0);
    chk({tag, " busy"}, 64'(busys), multi ? 64'(sh) : 64'd0);
    last_res = er;
    @(negedge clk);
    chk({tag, " pulse"}, 64'(bus.out_valid), 64'd0);
  endtask

  vec_t vecs[17];

  initial begin
    logic [31:0] er;
    logic        eo;
    int          seen;

    vecs[0]  = '{4'b0001, 32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b1};
    vecs[1]  = '{4'b0010, 32'h00000005, 32'h00000005, 5'd0,  32'h00000000, 1'b0};
    vecs[2]  = '{4'b0111, 32'h00000000, 32'h00000000, 5'd0,  32'hFFFFFFFF, 1'b0};
    vecs[3]  = '{4'b1010, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000001, 1'b0};
    vecs[4]  = '{4'b1001, 32'h00000002, 32'h00000003, 5'd0,  32'h00000005, 1'b0};
    vecs[5]  = '{4'b0000, 32'h00000000, 32'h00000001, 5'd4,  32'h00000010, 1'b0};
    vecs[6]  = '{4'b1111, 32'h00000000, 32'h80000000, 5'd31, 32'h00000001, 1'b0};
    vecs[7]  = '{4'b0000, 32'h11111111, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 1'b0};
    vecs[8]  = '{4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000, 1'b0};
    vecs[9]  = '{4'b0101, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hFFF0FFF0, 1'b0};
    vecs[10] = '{4'b0110, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'h0FF00FF0, 1'b0};
    vecs[11] = '{4'b0010, 32'h80000000, 32'h00000001, 5'd0,  32'h7FFFFFFF, 1'b1};
    vecs[12] = '{4'b1010, 32'h00000001, 32'hFFFFFFFF, 5'd0,  32'h00000000, 1'b0};
    vecs[13] = '{4'b1111, 32'h00000000, 32'h12345678, 5'd0,  32'h12345678, 1'b0};
    vecs[14] = '{4'b0001, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1'b0};
    vecs[15] = '{4'b0000, 32'h00000000, 32'hFFFFFFFF, 5'd31, 32'h80000000, 1'b0};
    vecs[16] = '{4'b0001, 32'h80000000, 32'h80000000, 5'd0,  32'h00000000, 1'b1};

    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.alu_ctrl = '0;
    bus.src_a = '0; bus.src_b = '0; bus.shamt = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst result", 64'(bus.result), 64'd0);
    chk("rst zero", 64'(bus.zero), 64'd0);
    chk("rst overflow", 64'(bus.overflow), 64'd0);
    chk("rst busy", 64'(bus.busy), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst in_ready", 64'(bus.in_ready), 64'd1);

    for (int i = 0; i < 17; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].sh,
             vecs[i].res, vecs[i].ovf);
    end

    // Back-to-back: sub 5-5 then nor 0,0 on consecutive cycles
    bus.in_valid = 1'b1; bus.alu_ctrl = 4'b0010; bus.src_a = 32'd5; bus.src_b = 32'd5; bus.shamt = '0;
    @(negedge clk);
    chk("b2b sub valid", 64'(bus.out_valid), 64'd1);
    chk("b2b sub result", 64'(bus.result), 64'd0);
    chk("b2b sub zero", 64'(bus.zero), 64'd1);
    bus.alu_ctrl = 4'b0111; bus.src_a = 32'd0; bus.src_b = 32'd0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("b2b nor valid", 64'(bus.out_valid), 64'd1);
    chk("b2b nor result", 64'(bus.result), 64'hFFFFFFFF);
    chk("b2b nor zero", 64'(bus.zero), 64'd0);
    last_res = 32'hFFFFFFFF;
    @(negedge clk);

    // Randomized ops against the reference model
    for (int i = 0; i < 150; i++) begin
      logic [3:0]  c;
      logic [31:0] a, b;
      logic [4:0]  sh;
      c  = 4'($urandom_range(0, 15));
      a  = (i % 7 == 0) ? 32'h7FFFFFFF : $urandom;
      b  = (i % 11 == 0) ? 32'h80000000 : $urandom;
      sh = 5'($urandom_range(0, 31));
      model(c, a, b, sh, er, eo);
      run_op($sformatf("rand%0d", i), c, a, b, sh, er, eo);
    end

    // Flush in IDLE drops the op offered in the same cycle
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.alu_ctrl = 4'b0001;
    bus.src_a = 32'd1; bus.src_b = 32'd1;
    @(negedge clk);
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    chk("flush idle valid", 64'(bus.out_valid), 64'd0);
    chk("flush idle result", 64'(bus.result), 64'(last_res));

    // srl shamt=8 flushed on its 3rd SHIFT cycle
    bus.in_valid = 1'b1; bus.alu_ctrl = 4'b1111; bus.src_b = 32'hF0000000; bus.shamt = 5'd8;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("flush shift busy", 64'(bus.busy), 64'd1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush shift in_ready", 64'(bus.in_ready), 64'd1);
    chk("flush shift idle", 64'(bus.busy), 64'd0);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (bus.out_valid) seen++;
      @(negedge clk);
    end
    chk("flush shift no valid", 64'(seen), 64'd0);
    chk("flush shift result", 64'(bus.result), 64'(last_res));

    // Reset mid-shift after a nonzero result
    run_op("pre-rst add", 4'b0001, 32'd2, 32'd3, 5'd0, 32'd5, 1'b0);
    bus.in_valid = 1'b1; bus.alu_ctrl = 4'b0000; bus.src_b = 32'h3; bus.shamt = 5'd20;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst result", 64'(bus.result), 64'd0);
    chk("midrst busy", 64'(bus.busy), 64'd0);
    chk("midrst out_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("midrst no partial", 64'(seen), 64'd0);
    chk("midrst in_ready", 64'(bus.in_ready), 64'd1);
    run_op("post-rst sll", 4'b0000, 32'd0, 32'h3, 5'd2, 32'hC, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
